wr_resp_sched: RTL and testbench
================================

WR_RESP_SCHED -- requirements
Module: wr_resp_sched

Interface
- REQ-001: Parameter ID_W, default 4, width of AXI write-response ID.
- REQ-002: Parameter DEPTH, default 4, response queue entries; legal values 2, 4, 8.
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset (asserted at 0).
- REQ-005: req0_valid  input  1  write-completion source has a response.
- REQ-006: req0_ready  output  1  response from source 0 accepted this cycle.
- REQ-007: req0_id  input  ID_W  ID for source 0 response.
- REQ-008: req0_resp  input  2  BRESP code for source 0.
- REQ-009: req1_valid / req1_ready / req1_id / req1_resp  same as REQ-005..008 for error/decode source 1.
- REQ-010: bid  output  ID_W  AXI write-response ID.
- REQ-011: bresp  output  2  AXI write-response code.
- REQ-012: bvalid  output  1  AXI write-response valid.
- REQ-013: bready  input  1  AXI master accepts response.
- REQ-014: err_cnt  output  8  count of non-OKAY responses delivered on B channel.
- REQ-015: q_full  output  1  queue holds DEPTH entries.

Function
- REQ-016: Queue is a DEPTH-entry FIFO of {id, resp}; write pointer, read pointer (log2 DEPTH bits, natural wrap) and occupancy count (0..DEPTH).
- REQ-017: Arbiter states: LAST0, LAST1 (last source granted); reset state LAST1, so source 0 wins first contention.
- REQ-018: Only one valid -> that source granted; both valid -> source other than last-granted granted; neither valid -> no grant, state held.
- REQ-019: reqN_ready = grantN AND NOT q_full; combinational, may depend on reqN_valid; never asserted for both sources in one cycle.
- REQ-020: Push occurs when reqN_valid AND reqN_ready; entry written at write pointer, pointer increments; arbiter state updates to LASTN only on push.
- REQ-021: When full, no push, arbiter state held, no ready asserted regardless of a pop in the same cycle (no pass-through).
- REQ-022: bvalid = (count != 0); bid/bresp = head entry when bvalid=1, else 0.
- REQ-023: Pop occurs when bvalid AND bready; read pointer increments.
- REQ-024: Push and pop in same cycle -> count unchanged; push only -> +1; pop only -> -1.
- REQ-025: Latency: response pushed in cycle N appears on B channel no earlier than cycle N+1; no combinational path from reqN_* to bid/bresp/bvalid.
- REQ-026: Ordering: responses delivered in push order; bid/bresp stable while bvalid=1 and bready=0.
- REQ-027: err_cnt increments on each pop with bresp != 2'b00; saturates at 255.
- REQ-028: q_full = (count == DEPTH).

Reset
- REQ-029: reset=0 asynchronously clears count, both pointers, err_cnt, forces arbiter to LAST1; bvalid, bid, bresp, q_full, req0_ready, req1_ready all 0 while reset=0.
- REQ-030: Reset mid-transfer discards all queued entries; queue storage contents need not be cleared.
- REQ-031: First push accepted on first rising edge after reset deasserts.

Verification
- REQ-032: Single: req0_valid=1 id=3 resp=00 one cycle, bready=1 -> req0_ready=1 that cycle; next cycle bvalid=1 bid=3 bresp=00; err_cnt stays 0.
- REQ-033: Contention: both valid continuously, ids 1 (src0) and 2 (src1), bready=1 -> accepted order 1,2,1,2...; B-channel ids same order.
- REQ-034: Backpressure: bready=0, req0 pushes 5 responses ids 0..4 -> ids 0..3 accepted, q_full=1, req0_ready=0 for id 4; raise bready -> B delivers 0,1,2,3,4 in order, bid stable while stalled.
- REQ-035: Errors: push resp 10, 11, 00, 10 and drain -> err_cnt=3; drive 260 SLVERR responses -> err_cnt=255.
- REQ-036: Reset with 3 entries queued -> bvalid=0 immediately (asynchronous), after release count=0, first new push appears with its own id.
- REQ-037: Full with simultaneous pop and req valid -> pop completes, no push that cycle, count DEPTH-1 next cycle.

Source files
------------

// File: rtl/wr_resp_sched.sv
// Write-response scheduler: two completion sources share one AXI B channel.
// A round-robin arbiter picks a source, responses go through a small FIFO,
// and the head of the FIFO drives the B channel. Non-OKAY responses that
// leave on the B channel are counted in a saturating counter.
module wr_resp_sched #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [ID_W-1:0] req0_id,
  input  logic [1:0]      req0_resp,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [ID_W-1:0] req1_id,
  input  logic [1:0]      req1_resp,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready,
  output logic [7:0]      err_cnt,
  output logic            q_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ID_W + 2;

  typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} arb_e;

  arb_e              arb_q;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        err_q, err_d;
  logic              grant0, grant1;
  logic              push0, push1, push, pop;
  logic [ENT_W-1:0]  push_ent, head;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Arbitration, handshakes and B-channel view of the queue head.
  always_comb begin
    q_full = (cnt_q == CNT_W'(DEPTH));
    grant0 = req0_valid & (~req1_valid | (arb_q == LAST1));
    grant1 = req1_valid & (~req0_valid | (arb_q == LAST0));
    // Ready is gated by reset so nothing looks accepted while the queue is held clear.
    req0_ready = grant0 & ~q_full & reset;
    req1_ready = grant1 & ~q_full & reset;
    push0 = req0_valid & req0_ready;
    push1 = req1_valid & req1_ready;
    push = push0 | push1;
    push_ent = push1 ? {req1_id, req1_resp} : {req0_id, req0_resp};
    head = mem_q[rd_ptr_q];
    bvalid = (cnt_q != '0);
    bid = bvalid ? head[ENT_W-1:2] : '0;
    bresp = bvalid ? head[1:0] : '0;
    pop = bvalid & bready;
  end

  // Next-state for pointers, occupancy and the error counter.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    err_d = (pop && (bresp != 2'b00)) ? sat_inc8(err_q) : err_q;
  end

  // Control state: pointers, count, error counter, arbiter history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      arb_q <= LAST1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (push0) arb_q <= LAST0;
      else if (push1) arb_q <= LAST1;
    end
  end

  // Queue storage; stale contents are harmless because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_ent;
  end

  assign err_cnt = err_q;

endmodule

// File: tb/tb_wr_resp_sched.sv
// Directed bench for wr_resp_sched with a queue-based reference model.
module tb_wr_resp_sched;

  localparam int ID_W  = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0_valid, req0_ready;
  logic [ID_W-1:0] req0_id;
  logic [1:0]      req0_resp;
  logic            req1_valid, req1_ready;
  logic [ID_W-1:0] req1_id;
  logic [1:0]      req1_resp;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [7:0]      err_cnt;
  logic            q_full;

  int checks = 0;
  int errors = 0;

  logic [ID_W+1:0] mq[$];
  bit              m_last;
  int              m_err;

  wr_resp_sched #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_id(req0_id), .req0_resp(req0_resp),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_id(req1_id), .req1_resp(req1_resp),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .err_cnt(err_cnt), .q_full(q_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 1'b1;
    m_err = 0;
  endtask

  // Compare this cycle's outputs with the model, then advance model and clock.
  task automatic cycle();
    bit full, g0, g1, r0, r1, bv;
    logic [ID_W+1:0] hd, e;
    #2;
    full = (mq.size() == DEPTH);
    g0 = req0_valid && (!req1_valid || m_last);
    g1 = req1_valid && (!req0_valid || !m_last);
    r0 = g0 && !full;
    r1 = g1 && !full;
    bv = (mq.size() != 0);
    hd = bv ? mq[0] : '0;
    chk("req0_ready", req0_ready, r0);
    chk("req1_ready", req1_ready, r1);
    chk("bvalid", bvalid, bv);
    chk("bid", bid, hd[ID_W+1:2]);
    chk("bresp", bresp, hd[1:0]);
    chk("q_full", q_full, full);
    chk("err_cnt", err_cnt, m_err);
    if (bv && bready) begin
      e = mq.pop_front();
      if (e[1:0] != 2'b00 && m_err != 255) m_err++;
    end
    if (r0) begin
      mq.push_back({req0_id, req0_resp});
      m_last = 1'b0;
    end else if (r1) begin
      mq.push_back({req1_id, req1_resp});
      m_last = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    req0_valid = 1'b1; req0_id = '0; req0_resp = 2'b00;
    req1_valid = 1'b0; req1_id = '0; req1_resp = 2'b00;
    bready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with a request pending to prove ready is held low.
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_q_full", q_full, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_err_cnt", err_cnt, 0);
    req0_valid = 1'b0;
    reset = 1'b1;

    // Contention: both sources valid, source 0 wins first.
    req0_valid = 1'b1; req0_id = 4'd1;
    req1_valid = 1'b1; req1_id = 4'd2;
    bready = 1'b1;
    #1;
    chk("cont_first_r0", req0_ready, 1);
    chk("cont_first_r1", req1_ready, 0);
    repeat (8) cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) cycle();

    // Single response from source 0.
    req0_valid = 1'b1; req0_id = 4'd3; req0_resp = 2'b00;
    cycle();
    req0_valid = 1'b0;
    #1;
    chk("single_bvalid", bvalid, 1);
    chk("single_bid", bid, 3);
    chk("single_bresp", bresp, 0);
    cycle();
    chk("single_err", err_cnt, 0);

    // Backpressure: five pushes into a four-entry queue.
    bready = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_id = ID_W'(i);
      cycle();
    end
    #1;
    chk("bp_full", q_full, 1);
    chk("bp_ready_id4", req0_ready, 0);
    chk("bp_head", bid, 0);
    repeat (3) cycle();
    chk("bp_stall_bid", bid, 0);
    // Full with a pop and a valid request: pop only, no push.
    bready = 1'b1;
    #1;
    chk("full_pop_ready", req0_ready, 0);
    cycle();
    chk("after_pop_full", q_full, 0);
    chk("after_pop_bid", bid, 1);
    cycle();
    req0_valid = 1'b0;
    repeat (6) cycle();

    // Error responses: 10, 11, 00, 10.
    req0_valid = 1'b1;
    req0_id = 4'd5; req0_resp = 2'b10; cycle();
    req0_id = 4'd6; req0_resp = 2'b11; cycle();
    req0_id = 4'd7; req0_resp = 2'b00; cycle();
    req0_id = 4'd8; req0_resp = 2'b10; cycle();
    req0_valid = 1'b0;
    repeat (3) cycle();
    chk("err_three", err_cnt, 3);

    // Saturation: 260 SLVERR responses.
    req0_valid = 1'b1; req0_resp = 2'b10;
    for (int i = 0; i < 260; i++) begin
      req0_id = ID_W'(i);
      cycle();
    end
    req0_valid = 1'b0;
    repeat (3) cycle();
    chk("err_sat", err_cnt, 255);

    // Asynchronous reset with three entries queued.
    bready = 1'b0;
    req0_valid = 1'b1; req0_resp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      req0_id = ID_W'(i + 10);
      cycle();
    end
    reset = 1'b0;
    #1;
    chk("arst_bvalid", bvalid, 0);
    chk("arst_bid", bid, 0);
    chk("arst_ready", req0_ready, 0);
    chk("arst_err", err_cnt, 0);
    model_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    req0_id = 4'd9; req0_resp = 2'b01;
    bready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_bvalid", bvalid, 1);
    chk("post_rst_bid", bid, 9);
    chk("post_rst_bresp", bresp, 1);
    mq.push_back({4'd9, 2'b01});
    m_last = 1'b0;
    req0_valid = 1'b0;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
